// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes and the fetch-queue
// entry and state types used by the instruction-fetch front end.
package mips32_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {
    T_RR_ALU  = 3'b000,
    T_RM_ALU  = 3'b001,
    T_LOAD    = 3'b010,
    T_STORE   = 3'b011,
    T_BRANCH  = 3'b100,
    T_HALT    = 3'b101,
    T_INVALID = 3'b111
  } instr_type_e;

  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] npc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_RUN   = 2'd0,
    FQ_HOLD  = 2'd1,
    FQ_FLUSH = 2'd2
  } fq_state_e;

  // Classify an opcode into the execution class the decode stage dispatches on.
  function automatic instr_type_e instr_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = T_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = T_RM_ALU;
      OP_LW:                                         t = T_LOAD;
      OP_SW:                                         t = T_STORE;
      OP_BNEQZ, OP_BEQZ:                             t = T_BRANCH;
      OP_HLT:                                        t = T_HALT;
      default:                                       t = T_INVALID;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, branch redirect, halt and
// the decode-side valid/ready handshake.
interface mips32_fetch_queue_if
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic              imem_rvalid;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_ir;
  logic [WORD_W-1:0] out_npc;

  modport master (
    output imem_req, imem_addr, out_valid, out_ir, out_npc,
    input  imem_rdata, imem_rvalid, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_ir, out_npc,
    output imem_rdata, imem_rvalid, redirect_valid, redirect_pc, halt, out_ready
  );

endinterface

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
// Depth must be a power of two so the pointers wrap naturally.
module mips32_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: issues word reads, buffers responses in a
// prefetch FIFO and hands {ir, npc} to decode; branches redirect and flush it.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mips32_fetch_queue_if.master fq
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fq_state_e         state_q;
  fq_state_e         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              inflight_q;
  logic              drop_q;
  logic [WORD_W-1:0] last_ir_q;
  logic [WORD_W-1:0] last_npc_q;

  logic              issue_c;
  logic              push_c;
  logic              pop_c;
  logic [OCC_W-1:0]  occ_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FQ_RUN;
    else     state_q <= state_d;
  end

  // A redirect overrides any halt-driven transition for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FQ_RUN:   if (fq.halt)  state_d = FQ_HOLD;
      FQ_HOLD:  if (!fq.halt) state_d = FQ_RUN;
      FQ_FLUSH: state_d = fq.halt ? FQ_HOLD : FQ_RUN;
      default:  state_d = FQ_RUN;
    endcase
    if (fq.redirect_valid) state_d = FQ_FLUSH;
  end

  // Issue follows the state being entered, so halt/redirect block it in the same
  // cycle; every outstanding read must already own a free FIFO slot.
  always_comb begin
    occ_c   = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    issue_c = !rst && (state_d == FQ_RUN) && !fifo_full
              && (occ_c <= OCC_W'(DEPTH - 1));
    pop_c   = !fifo_empty && fq.out_ready && !fq.redirect_valid;
    push_c  = fq.imem_rvalid && inflight_q && !drop_q && !fq.redirect_valid;
    push_entry.ir  = fq.imem_rdata;
    push_entry.npc = WORD_W'(req_addr_q) + WORD_W'(1);
  end

  mips32_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .flush     (fq.redirect_valid),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      last_ir_q  <= '0;
      last_npc_q <= '0;
    end else begin
      if (fq.redirect_valid) pc_q <= fq.redirect_pc;
      else if (issue_c)      pc_q <= pc_q + ADDR_W'(1);

      if (issue_c) req_addr_q <= pc_q;

      if (issue_c)               inflight_q <= 1'b1;
      else if (fq.imem_rvalid)   inflight_q <= 1'b0;

      // A response landing in the redirect cycle is discarded by the flush;
      // only a still-pending read needs to be marked for dropping.
      if (fq.redirect_valid)     drop_q <= inflight_q && !fq.imem_rvalid;
      else if (fq.imem_rvalid)   drop_q <= 1'b0;

      last_ir_q  <= fq.out_ir;
      last_npc_q <= fq.out_npc;
    end
  end

  // With the FIFO empty the outputs keep showing what they showed last cycle.
  assign fq.imem_req  = issue_c;
  assign fq.imem_addr = pc_q;
  assign fq.out_valid = !fifo_empty;
  assign fq.out_ir    = fifo_empty ? last_ir_q  : head.ir;
  assign fq.out_npc   = fifo_empty ? last_npc_q : head.npc;

endmodule

// File: doc/mips32_fetch_queue.md
# mips32_fetch_queue

Instruction-fetch front end for the MIPS32 pipeline. It issues word reads to instruction memory, buffers returned instructions in a small prefetch FIFO, and presents them with their next-PC to the decode stage via a valid/ready handshake. Taken branches resolved in EX/MEM redirect it. Redirects flush the queue and discard in-flight reads. A halt input freezes new fetches.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `ADDR_W`, 10: instruction word-address width (1024-word memory).
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_req`  out  1: read request this cycle.
- `imem_addr`  out  ADDR_W: word address of the request.
- `imem_rdata`  in  32: instruction word; valid when `imem_rvalid`.
- `imem_rvalid`  in  1: response, exactly one cycle after its `imem_req`.
- `redirect_valid`  in  1: taken branch; one-cycle pulse.
- `redirect_pc`  in  ADDR_W: branch target word address.
- `halt`  in  1: level; while high, no new requests.
- `out_valid`  out  1: head entry available to decode.
- `out_ready`  in  1: decode accepts head this cycle.
- `out_ir`  out  32: head instruction word.
- `out_npc`  out  32: zero-extended head address + 1 (32-bit add, no wrap).

## Operation
- Registers: `pc`, FIFO (`DEPTH` × {ir, npc}), `count`, `inflight` flag, `drop` flag.
- Issue rule: `imem_req` = !rst && !halt && !redirect_valid && (count + inflight + pop_this_cycle ≤ DEPTH − 1 + pop_this_cycle). Equivalently, a slot must be reserved for every outstanding read. `imem_addr` = `pc`. On issue, `pc` ← `pc` + 1, wrapping modulo 2^ADDR_W (1023 → 0).
- Response: when `imem_rvalid` && !`drop`, push {`imem_rdata`, addr_of_request + 1}. The request address is held in a register alongside `inflight`. When `imem_rvalid` && `drop`, discard the response and clear `drop`.
- Pop: `out_valid` && `out_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority):
  - count ← 0; FIFO pointers reset; `pc` ← `redirect_pc`.
  - If a read is in flight, `drop` ← 1.
  - A pop in the same cycle is ignored; no consumer-side side effect.
  - No request in the redirect cycle; the target is fetched in the next cycle unless `halt` is high.
- Halt: blocks issue only. In-flight responses are still accepted. Decode may keep draining. Redirect while halted still flushes and updates `pc`. Deasserting `halt` resumes at `pc`.
- FSM `fsm_state` ∈ {RUN, HOLD, FLUSH}:
  - RUN→HOLD when `halt`.
  - HOLD→RUN when !`halt`.
  - Any→FLUSH on `redirect_valid`.
  - FLUSH→RUN (or HOLD if `halt`) after one cycle.
  - Issue is allowed only in RUN.
- Full FIFO: no issue; `imem_rvalid` never arrives to a full FIFO, because of the reservation rule.
- Empty FIFO: `out_valid` = 0; `out_ir`/`out_npc` hold their last values.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = RESET_PC, `out_valid` = 0, `out_ir` = 0, `out_npc` = 0.
  - `count` = 0, `inflight` = 0, `drop` = 0, state RUN.
- Reset mid-operation clears everything in that cycle. A response arriving in the cycle after reset is ignored.
- First `imem_req` occurs in the first cycle with `rst` low.
- Latency: request in cycle T → `imem_rvalid` in T+1 → `out_valid` in T+2, with no bypass.
- Steady-state throughput: one instruction per cycle when `out_ready` is held high.
- Redirect in cycle R → target request in R+1 → target at `out` in R+3.

## Structure
- Shared package `mips32_pkg`:
  - opcode constants (ADD…BEQZ, HLT) and instruction-type codes.
  - `IMEM_ADDR_W` = 10.
  - typedef `fetch_entry_t` {ir[31:0], npc[31:0]}.
- Sub-module `mips32_sync_fifo`: parameterised width/depth, with push, pop, flush, count, full, empty. The FSM, issue logic and drop tracking stay in the top module.

## Test plan
- Reset, `out_ready`=1, memory[k]=k+100 → `imem_addr` 0,1,2,…. `out_ir` 100,101,102 from cycle 2 on, one per cycle; `out_npc` 1,2,3.
- `out_ready`=0 for 10 cycles → exactly 4 entries buffered; `imem_req` stays low; no overflow. Release → 4 entries in order, then streaming resumes.
- `redirect_valid` with `redirect_pc`=50 while 3 are buffered and 1 is in flight → the in-flight response is dropped, the FIFO is emptied, and the next `out_ir` = memory[50] with `out_npc`=51, three cycles later.
- `halt` high for 5 cycles, then redirect to 7 during the halt → no requests while halted. On release, the first request is at addr 7.
- `pc` at 1023 → next `imem_addr` 0; `out_npc` for addr 1023 = 1024.
- Assert `rst` with the FIFO full and a read in flight → next cycle `out_valid`=0, `count`=0. The first post-reset output is memory[RESET_PC].
